apb_timer: RTL and testbench

- APB slave holding a 64-bit free-running machine timer, a 64-bit compare register and control/status registers.
- Drives the CPU `interrupt` input and answers CPU loads and stores on the shared APB bus.
- Sits downstream of the CPU's APB master, behind the interconnect address decode; it is selected by `APB_psel`.

---
 rtl/apb_timer_if.sv | 25 ++
 rtl/apb_timer.sv | 171 +++++++++++++++++
 tb/tb_apb_timer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_if.sv
// rtl/apb_timer_if.sv - APB bus bundle between the CPU master and the timer slave
interface apb_timer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] APB_paddr;
  logic [DATA_WIDTH-1:0] APB_pdata;
  logic [DATA_WIDTH-1:0] APB_prdata;
  logic                  APB_psel;
  logic                  APB_penable;
  logic                  APB_pwrite;
  logic [3:0]            APB_pstb;
  logic                  APB_pready;
  logic                  APB_perr;

  modport master (
    output APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    input  APB_prdata, APB_pready, APB_perr
  );

  modport slave (
    input  APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    output APB_prdata, APB_pready, APB_perr
  );
endinterface

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB machine timer: 64-bit mtime/mtimecmp, prescaler, pending interrupt
// Optional APB_TIMER_LATCH_EN: MTIME_LO read latches mtime[63:32] for an atomic HI read.
module apb_timer #(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [7:0] PRESCALE_RST = 8'd0
) (
  input  logic       clk,
  input  logic       rts,
  apb_timer_if.slave apb,
  output logic       interrupt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d, irq_en_q, irq_en_d, reload_q, reload_d;
  logic        pending_q, pending_d;
  logic [7:0]  prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic [31:0] prdata_q, prdata_d;
  logic        perr_q, perr_d;

  logic [2:0]  idx;
  logic        invalid, wr_en, tick, match;
  logic [31:0] ctrl_rd, ctrl_wd, rdata, hi_rd;
  logic        unused_paddr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] stb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = stb[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  assign idx          = apb.APB_paddr[4:2];
  assign invalid      = (idx == 3'd6) || (idx == 3'd7);
  assign unused_paddr = ^{apb.APB_paddr[ADDR_WIDTH-1:5], apb.APB_paddr[1:0]};
  assign ctrl_rd      = {16'd0, prescale_q, 5'd0, reload_q, irq_en_q, en_q};
  assign ctrl_wd      = merge(ctrl_rd, apb.APB_pdata, apb.APB_pstb);
  // Commit happens on the edge that ends DONE, i.e. while pready is high.
  assign wr_en        = (state_q == DONE) && apb.APB_psel && apb.APB_pwrite;

  assign apb.APB_pready = (state_q == DONE);
  assign apb.APB_prdata = prdata_q;
  assign apb.APB_perr   = perr_q;
  assign interrupt      = pending_q && irq_en_q;

`ifdef APB_TIMER_LATCH_EN
  logic [31:0] shadow_q, shadow_d;

  assign hi_rd = shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (state_q == ACCESS && apb.APB_psel && !apb.APB_pwrite && idx == 3'd0)
      shadow_d = mtime_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (rts) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end
`else
  assign hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata = mtime_q[31:0];
      3'd1:    rdata = hi_rd;
      3'd2:    rdata = cmp_q[31:0];
      3'd3:    rdata = cmp_q[63:32];
      3'd4:    rdata = ctrl_rd;
      3'd5:    rdata = {31'd0, pending_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prdata_d = prdata_q;
    perr_d   = perr_q;
    case (state_q)
      IDLE:   if (apb.APB_psel && apb.APB_penable) state_d = ACCESS;
      ACCESS: begin
        if (!apb.APB_psel) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          prdata_d = apb.APB_pwrite ? 32'd0 : rdata;
          perr_d   = invalid;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick       = en_q && (pcnt_q == prescale_q);
    match      = en_q && (mtime_q >= cmp_q);
    mtime_d    = mtime_q;
    cmp_d      = cmp_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    pending_d  = pending_q;
    pcnt_d     = pcnt_q;

    if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (match && reload_q) mtime_d = '0;

    if (wr_en) begin
      case (idx)
        3'd0: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], apb.APB_pdata, apb.APB_pstb)};
        3'd1: mtime_d = {merge(mtime_q[63:32], apb.APB_pdata, apb.APB_pstb), mtime_q[31:0]};
        3'd2: cmp_d   = {cmp_q[63:32], merge(cmp_q[31:0], apb.APB_pdata, apb.APB_pstb)};
        3'd3: cmp_d   = {merge(cmp_q[63:32], apb.APB_pdata, apb.APB_pstb), cmp_q[31:0]};
        3'd4: begin
          en_d       = ctrl_wd[0];
          irq_en_d   = ctrl_wd[1];
          reload_d   = ctrl_wd[2];
          prescale_d = ctrl_wd[15:8];
          pcnt_d     = 8'd0;
        end
        3'd5: if (apb.APB_pstb[0] && apb.APB_pdata[0]) pending_d = 1'b0;
        default: ;
      endcase
    end

    // A match on the same edge as a STATUS clear keeps pending set.
    if (match) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rts) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rts) begin
      mtime_q    <= '0;
      cmp_q      <= '1;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      reload_q   <= 1'b0;
      prescale_q <= PRESCALE_RST;
      pending_q  <= 1'b0;
      pcnt_q     <= 8'd0;
      prdata_q   <= '0;
      perr_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
      pending_q  <= pending_d;
      pcnt_q     <= pcnt_d;
      prdata_q   <= prdata_d;
      perr_q     <= perr_d;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - scoreboard bench for apb_timer
module tb_apb_timer;

  localparam logic [31:0] A_MLO = 32'h00, A_MHI = 32'h04, A_CLO = 32'h08, A_CHI = 32'h0C;
  localparam logic [31:0] A_CTRL = 32'h10, A_STAT = 32'h14, A_BAD6 = 32'h18, A_BAD7 = 32'h1C;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          cap;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rts = 1'b1;
  logic irq;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] v0, v1;
  exp_t exp_q[$];

  apb_timer_if bus ();

  apb_timer dut (
    .clk       (clk),
    .rts       (rts),
    .apb       (bus),
    .interrupt (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input logic [31:0] act,
                           input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if ($isunknown(act) || act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h..%h", name, act, lo, hi);
    end
  endtask

  // Monitor: every pready pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rts && bus.APB_pready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready: actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_perr"}, {31'd0, bus.APB_perr}, {31'd0, e.err});
        if (e.cap) last_rdata = bus.APB_prdata;
        else chk(e.name, bus.APB_prdata, e.data);
      end
    end
  end

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] stb, input logic [31:0] exp_data, input bit err,
                     input bit cap, input string name);
    int lat;
    exp_t e;
    e.data = exp_data; e.err = err; e.cap = cap; e.name = name;
    exp_q.push_back(e);
    bus.APB_psel = 1'b1; bus.APB_pwrite = wr; bus.APB_paddr = addr;
    bus.APB_pdata = data; bus.APB_pstb = stb; bus.APB_penable = 1'b0;
    @(posedge clk); #1 bus.APB_penable = 1'b1;
    lat = 0;
    while (bus.APB_pready !== 1'b1 && lat < 8) begin
      @(posedge clk); #1 lat++;
    end
    chk({name, "_latency"}, lat, 2);
    @(posedge clk); #1 bus.APB_psel = 1'b0; bus.APB_penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string name);
    apb(1'b1, addr, data, 4'hF, 32'd0, 1'b0, 1'b1, name);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input string name);
    apb(1'b0, addr, 32'd0, 4'h0, exp_data, 1'b0, 1'b0, name);
  endtask

  task automatic rdcap(input logic [31:0] addr, input string name);
    apb(1'b0, addr, 32'd0, 4'h0, 32'd0, 1'b0, 1'b1, name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    bit seen;
    logic [31:0] exp_hi;
    bus.APB_psel = 1'b0; bus.APB_penable = 1'b0; bus.APB_pwrite = 1'b0;
    bus.APB_paddr = '0; bus.APB_pdata = '0; bus.APB_pstb = 4'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", {31'd0, bus.APB_pready}, 32'd0);
    chk("rst_perr", {31'd0, bus.APB_perr}, 32'd0);
    chk("rst_prdata", bus.APB_prdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rts = 1'b0;

    rd(A_MLO, 32'h0, "rst_mtime_lo");
    rd(A_MHI, 32'h0, "rst_mtime_hi");
    rd(A_CLO, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(A_CHI, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_STAT, 32'h0, "rst_status");

    wr(A_CTRL, 32'hFFFF_FFFF, "ctrl_all");
    rd(A_CTRL, 32'h0000_FF07, "ctrl_mask");
    wr(A_CTRL, 32'h0, "ctrl_off");

    wr(A_MLO, 32'h0, "cnt_mlo");
    wr(A_MHI, 32'h0, "cnt_mhi");
    wr(A_CTRL, 32'h0000_0301, "cnt_ctrl");
    repeat (40) @(posedge clk);
    #1 wr(A_CTRL, 32'h0, "cnt_stop");
    rdcap(A_MLO, "cnt_rd1");
    v0 = last_rdata;
    chk_range("cnt_value", v0, 32'd9, 32'd11);
    repeat (10) @(posedge clk);
    #1 rdcap(A_MLO, "cnt_rd2");
    chk("cnt_frozen", last_rdata, v0);

    wr(A_MLO, 32'h0, "irq_mlo");
    wr(A_CHI, 32'h0, "irq_chi");
    wr(A_CLO, 32'h20, "irq_clo");
    wr(A_STAT, 32'h1, "irq_clr0");
    wr(A_CTRL, 32'h3, "irq_ctrl");
    cyc = 0;
    while (irq !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1 cyc++;
    end
    chk_range("irq_rise_cycles", cyc, 32'h21, 32'h23);
    wr(A_STAT, 32'h1, "irq_clr1");
    rd(A_STAT, 32'h1, "irq_pending_resets");
    chk("irq_still_high", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h1, "irq_mask");
    chk("irq_masked", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h0, "irq_off");
    wr(A_STAT, 32'h1, "irq_clr2");
    rd(A_STAT, 32'h0, "irq_cleared");

    wr(A_MLO, 32'h0, "rl_mlo");
    wr(A_CLO, 32'h5, "rl_clo");
    wr(A_CTRL, 32'h7, "rl_ctrl");
    repeat (20) @(posedge clk);
    #1 rd(A_STAT, 32'h1, "rl_pending");
    rdcap(A_MLO, "rl_mlo_rd");
    chk_range("rl_mtime_bound", last_rdata, 32'd0, 32'd5);
    wr(A_STAT, 32'h1, "rl_clr");
    repeat (10) @(posedge clk);
    #1 rd(A_STAT, 32'h1, "rl_pending_again");
    wr(A_CTRL, 32'h0, "rl_off");
    wr(A_STAT, 32'h1, "rl_clr2");

    wr(A_MLO, 32'hAABB_CCDD, "stb_full");
    apb(1'b1, A_MLO, 32'h0000_1234, 4'b0001, 32'd0, 1'b0, 1'b1, "stb_b0");
    rd(A_MLO, 32'hAABB_CC34, "stb_byte0");
    apb(1'b1, A_MLO, 32'h5555_5555, 4'b0000, 32'd0, 1'b0, 1'b1, "stb_none");
    rd(A_MLO, 32'hAABB_CC34, "stb_noop");

    bus.APB_psel = 1'b1; bus.APB_pwrite = 1'b1; bus.APB_paddr = A_MLO;
    bus.APB_pdata = 32'hDEAD_BEEF; bus.APB_pstb = 4'hF; bus.APB_penable = 1'b0;
    @(posedge clk); #1 bus.APB_penable = 1'b1;
    @(posedge clk); #1 bus.APB_psel = 1'b0; bus.APB_penable = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1 if (bus.APB_pready === 1'b1) seen = 1'b1;
    end
    chk("abort_no_pready", {31'd0, seen}, 32'd0);
    rd(A_MLO, 32'hAABB_CC34, "abort_no_commit");

    apb(1'b0, A_BAD6, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0, "bad_rd_18");
    apb(1'b1, A_BAD7, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, 1'b1, "bad_wr_1c");

    wr(A_CHI, 32'hFFFF_FFFF, "wrap_chi");
    wr(A_CLO, 32'hFFFF_FFFF, "wrap_clo");
    wr(A_MHI, 32'hFFFF_FFFF, "wrap_mhi");
    wr(A_MLO, 32'hFFFF_FFFE, "wrap_mlo");
    wr(A_CTRL, 32'h1, "wrap_en");
    wr(A_CTRL, 32'h0, "wrap_stop");
    rd(A_MLO, 32'h2, "wrap_lo");
    rd(A_MHI, 32'h0, "wrap_hi");
    wr(A_STAT, 32'h1, "wrap_clr");

    wr(A_MHI, 32'h0, "atom_mhi");
    wr(A_MLO, 32'hFFFF_FFFD, "atom_mlo");
    wr(A_CTRL, 32'h1, "atom_en");
    rd(A_MLO, 32'hFFFF_FFFF, "atom_lo");
`ifdef APB_TIMER_LATCH_EN
    exp_hi = 32'h0;
`else
    exp_hi = 32'h1;
`endif
    rd(A_MHI, exp_hi, "atom_hi");
    wr(A_CTRL, 32'h0, "atom_off");

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
